// File: rtl/gray_counter.sv
// gray_counter: registered binary/Gray up/down counter with load, wrap/saturate mode and boundary flags.
// Optional feature macro GRAY_COUNTER_STEP_CHECK_EN adds the step_err Gray-step integrity monitor.
module gray_counter #(
   parameter int unsigned WIDTH       = 4,
   parameter bit          WRAP        = 1'b1,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] gray_next,
   output logic             at_max,
   output logic             at_min,
   output logic             wrapped
`ifdef GRAY_COUNTER_STEP_CHECK_EN
   ,output logic            step_err
`endif
);
   localparam logic [WIDTH-1:0] RST_BIN  = RESET_VALUE[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
   logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, cnt_bin;
   logic             at_max_q, at_min_q, wrapped_q, wrapped_d, sat;
   // Next binary value by priority reset > load > en > hold; gray is derived from it, never from gray_q
   always_comb begin
      sat       = up ? (bin_q == '1) : (bin_q == '0);
      cnt_bin   = (sat && !WRAP) ? bin_q : up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      bin_d     = reset ? RST_BIN : load ? load_bin : en ? cnt_bin : bin_q;
      gray_d    = bin_d ^ (bin_d >> 1);
      wrapped_d = !reset && !load && en && sat && WRAP;
   end
   // State registers; flags decoded from the next binary value so they line up with bin
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q     <= RST_BIN;
         gray_q    <= RST_GRAY;
         at_max_q  <= (RST_BIN == '1);
         at_min_q  <= (RST_BIN == '0);
         wrapped_q <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         gray_q    <= gray_d;
         at_max_q  <= &bin_d;
         at_min_q  <= ~|bin_d;
         wrapped_q <= wrapped_d;
      end
   end
   assign bin       = bin_q;
   assign gray      = gray_q;
   assign gray_next = gray_d;
   assign at_max    = at_max_q;
   assign at_min    = at_min_q;
   assign wrapped   = wrapped_q;
`ifdef GRAY_COUNTER_STEP_CHECK_EN
   logic step_err_q, step_err_d;
   // A counting edge must flip exactly one gray bit, or none when holding saturated
   always_comb begin
      step_err_d = !reset && !load && en &&
                   ($countones(gray_d ^ gray_q) != ((sat && !WRAP) ? 0 : 1));
   end
   // Register the monitor flag as a one-cycle pulse
   always_ff @(posedge clk) begin
      step_err_q <= reset ? 1'b0 : step_err_d;
   end
   assign step_err = step_err_q;
`endif
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: randomized and directed checks of four gray_counter configurations against a behavioural model.
module tb_gray_counter;
   logic clk, reset, en, up, load;
   logic [7:0] lbin;
   logic [3:0] b0, g0, n0, b1, g1, n1, b2, g2, n2;
   logic [7:0] b3, g3, n3;
   logic mx_o[4], mn_o[4], wr_o[4], se[4];
   logic [7:0] ob[4], og[4], ogn[4];
   int n_cmp = 0, n_err = 0;
   int W[4] = '{4, 4, 4, 8};
   bit WR[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   int RV[4] = '{0, 0, 5, 0};
   int m_bin[4];

   gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VALUE(0)) d0 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lbin[3:0]),
      .bin(b0), .gray(g0), .gray_next(n0), .at_max(mx_o[0]), .at_min(mn_o[0]), .wrapped(wr_o[0])
`ifdef GRAY_COUNTER_STEP_CHECK_EN
      , .step_err(se[0])
`endif
   );
   gray_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VALUE(0)) d1 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lbin[3:0]),
      .bin(b1), .gray(g1), .gray_next(n1), .at_max(mx_o[1]), .at_min(mn_o[1]), .wrapped(wr_o[1])
`ifdef GRAY_COUNTER_STEP_CHECK_EN
      , .step_err(se[1])
`endif
   );
   gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VALUE(5)) d2 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lbin[3:0]),
      .bin(b2), .gray(g2), .gray_next(n2), .at_max(mx_o[2]), .at_min(mn_o[2]), .wrapped(wr_o[2])
`ifdef GRAY_COUNTER_STEP_CHECK_EN
      , .step_err(se[2])
`endif
   );
   gray_counter #(.WIDTH(8), .WRAP(1'b1), .RESET_VALUE(0)) d3 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(lbin),
      .bin(b3), .gray(g3), .gray_next(n3), .at_max(mx_o[3]), .at_min(mn_o[3]), .wrapped(wr_o[3])
`ifdef GRAY_COUNTER_STEP_CHECK_EN
      , .step_err(se[3])
`endif
   );

   assign ob[0] = {4'b0, b0}; assign og[0] = {4'b0, g0}; assign ogn[0] = {4'b0, n0};
   assign ob[1] = {4'b0, b1}; assign og[1] = {4'b0, g1}; assign ogn[1] = {4'b0, n1};
   assign ob[2] = {4'b0, b2}; assign og[2] = {4'b0, g2}; assign ogn[2] = {4'b0, n2};
   assign ob[3] = b3;         assign og[3] = g3;         assign ogn[3] = n3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int gry(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_next(input int k, input bit r, input bit l, input int lb, input bit e,
                             input bit u, output int nb, output bit nw);
      int mx;
      mx = (1 << W[k]) - 1;
      nb = m_bin[k];
      nw = 1'b0;
      if (r) nb = RV[k];
      else if (l) nb = lb & mx;
      else if (e && u) begin
         if (m_bin[k] != mx) nb = m_bin[k] + 1;
         else if (WR[k]) begin nb = 0; nw = 1'b1; end
      end else if (e) begin
         if (m_bin[k] != 0) nb = m_bin[k] - 1;
         else if (WR[k]) begin nb = mx; nw = 1'b1; end
      end
   endtask

   task automatic step(input bit r, input bit l, input int lb, input bit e, input bit u);
      int nb[4];
      bit nw[4];
      logic [7:0] pg[4];
      int mx;
      reset = r; load = l; lbin = lb[7:0]; en = e; up = u;
      #1;
      for (int k = 0; k < 4; k++) begin
         model_next(k, r, l, lb, e, u, nb[k], nw[k]);
         check($sformatf("d%0d.gray_next", k), ogn[k], gry(nb[k]));
         pg[k] = og[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         mx = (1 << W[k]) - 1;
         check($sformatf("d%0d.bin", k), ob[k], nb[k]);
         check($sformatf("d%0d.gray", k), og[k], gry(nb[k]));
         check($sformatf("d%0d.at_max", k), mx_o[k], nb[k] == mx);
         check($sformatf("d%0d.at_min", k), mn_o[k], nb[k] == 0);
         check($sformatf("d%0d.wrapped", k), wr_o[k], nw[k]);
         if (!r && !l && e)
            check($sformatf("d%0d.hamming", k), $countones(og[k] ^ pg[k]), (nb[k] != m_bin[k]) ? 1 : 0);
`ifdef GRAY_COUNTER_STEP_CHECK_EN
         check($sformatf("d%0d.step_err", k), se[k], 0);
`endif
         m_bin[k] = nb[k];
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; lbin = '0;
      for (int k = 0; k < 4; k++) m_bin[k] = 0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0);
      check("rst.d2.bin", ob[2], 5);
      check("rst.d2.gray", og[2], 7);
      check("rst.d0.at_min", mn_o[0], 1);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 1, 1);
         check("up.d0.wrapped", wr_o[0], i == 15);
         check("up.d0.at_max", mx_o[0], i == 14);
      end
      check("up.d0.bin", ob[0], 0);
      check("sat.d1.bin", ob[1], 15);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 1);
         check("sat.d1.hold", ob[1], 15);
         check("sat.d1.gray", og[1], 8);
         check("sat.d1.wrapped", wr_o[1], 0);
      end
      step(0, 0, 0, 1, 0);
      check("sat.d1.down", ob[1], 14);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      check("dn.d0.bin", ob[0], 15);
      check("dn.d0.gray", og[0], 8);
      check("dn.d0.wrapped", wr_o[0], 1);
      check("dn.d0.at_max", mx_o[0], 1);
      check("dn.d0.at_min", mn_o[0], 0);
      reset = 1'b0; load = 1'b1; lbin = 8'd9; en = 1'b1; up = 1'b1;
      #1;
      check("load.d0.gray_next", ogn[0], 13);
      step(0, 1, 9, 1, 1);
      check("load.d0.bin", ob[0], 9);
      check("load.d0.gray", og[0], 13);
      check("load.d0.wrapped", wr_o[0], 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      check("pri.d2.pre", ob[2], 7);
      step(1, 1, 3, 1, 1);
      check("pri.d2.bin", ob[2], 5);
      check("pri.d2.gray", og[2], 7);
      check("pri.d2.wrapped", wr_o[2], 0);
      for (int i = 0; i < 10000; i++) begin
         bit bias;
         bias = ((i / 500) % 2) == 1;
         step($urandom_range(63) == 0, $urandom_range(15) == 0, int'($urandom_range(255)),
              $urandom_range(3) != 0, bias ? ($urandom_range(7) != 0) : 1'($urandom_range(1)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
